poly_voice_allocator: RTL
=========================

// Module: poly_voice_allocator
// PURPOSE
//  Parametrised successor to the single-tone key path: turns NUM_KEYS debounced key levels into
//  press/release events and assigns each pressed key to one of NUM_VOICES oscillator voices.
//  When every voice is busy, the oldest voice is stolen. Sits between the per-key debouncers and
//  the per-voice period/envelope logic. Events leave through a valid/ready port to the envelope stage.
// PARAMETERS
//  NUM_KEYS    12  number of key inputs (>=2)
//  NUM_VOICES  4   number of voices (>=1)
//  AGE_W       8   width of each per-voice saturating age counter
// PORTS
//  clk           in   1                    system clock
//  rst           in   1                    async reset, active-high
//  keys_i        in   NUM_KEYS             debounced key levels, 1 = held
//  voice_active  out  NUM_VOICES           voice v is sounding a key
//  voice_key     out  NUM_VOICES*KEY_W     key index per voice; voice v occupies bits [v*KEY_W +: KEY_W]
//  evt_valid     out  1                    event available
//  evt_ready     in   1                    downstream accepts the event
//  evt_on        out  1                    1 = note-on, 0 = note-off
//  evt_key       out  KEY_W                key index of the event
//  evt_voice     out  VOICE_W              voice index of the event
//  evt_steal     out  1                    note-on took a busy voice
// BEHAVIOUR
//  Widths
//  - KEY_W = max(1, $clog2(NUM_KEYS)).
//  - VOICE_W = max(1, $clog2(NUM_VOICES)).
//  Reset
//  - Every output, keys_q, both pending masks, all ages and all voice_key entries reset to 0.
//  - Keys held through reset are seen as fresh presses afterwards.
//  Edge capture (every cycle)
//  - keys_q <= keys_i.
//  - A rise (keys_i & ~keys_q) sets press_pend[k].
//  - A fall (~keys_i & keys_q):
//    - if press_pend[k] is still set, clear it and raise no release (the press is cancelled);
//    - otherwise set rel_pend[k].
//  Issue slot
//  - Open when !evt_valid || evt_ready. Exactly one pending bit is consumed per open cycle.
//  - Priority: any rel_pend before any press_pend; within each class, lowest key index first.
//  - Latency: a key edge at clock T gives evt_valid at T+1 when the slot is open and nothing else is pending.
//  Release of key k
//  - If voice v holds k (voice_active[v] && voice_key[v]==k): voice_active[v]<=0; emit on=0, key=k, voice=v, steal=0.
//  - If no voice holds k (its voice was stolen): clear rel_pend[k], emit nothing, evt_valid <= 0.
//  Press of key k
//  - Free voice exists: pick the lowest-index free voice, steal=0.
//  - No free voice: pick the voice with the largest age (ties go to the lowest index), steal=1.
//  - The chosen voice: voice_key<=k, voice_active<=1, age<=0. Emit on=1.
//  Ages
//  - Every active voice that is not being assigned this cycle increments by 1, saturating at all-ones.
//  - Inactive voices hold their age.
//  Handshake
//  - A transfer happens when evt_valid && evt_ready.
//  - While evt_valid && !evt_ready, every evt_* field holds stable and no pending bit is consumed.
//  - Edge capture keeps running while stalled, so no key edge is lost.
//  - If the slot is open and nothing is pending, evt_valid <= 0.
//  Voice state timing
//  - Voice state updates in the same cycle the event is registered, not when it is accepted.
//  Async reset mid-operation: state clears immediately and no partial event survives.
// STRUCTURE
//  - synth_pkg: evt_kind_e (EVT_OFF, EVT_ON) and the clog2 width helper functions.
//  - Sub-module key_event_detector (keys_q register, press/release pending masks, priority pick).
//  - Voice table, age counters and oldest-voice search stay in this module.
// TESTING (NUM_KEYS=12, NUM_VOICES=4, AGE_W=8 unless stated)
//  1. keys_i=0x008 from cycle 0, evt_ready=1
//     -> cycle 1: evt on=1, key=3, voice=0, steal=0; voice_active=0001.
//  2. keys_i 0x000 -> 0x0A1 in one cycle
//     -> three consecutive events: keys 0, 5, 7 on voices 0, 1, 2; voice_active=0111.
//  3. Press keys 1, 2, 3, 4, 5 spaced 10 cycles apart
//     -> key 5 steals voice 0 (steal=1, voice_key[0]=5).
//     -> Releasing key 1 then produces no event.
//  4. Hold evt_ready=0 for 6 cycles while 2 events are pending
//     -> the evt_* fields stay stable, then both events are delivered in order with none lost.
//  5. Two presses pending, then key 2 rises and falls while the slot is blocked
//     -> no event for key 2 at all.
//  6. Assert rst during a stall with keys 0x003 held
//     -> outputs 0 at once; after reset, ON events for keys 0 and 1.

Source files
------------

// File: rtl/poly_voice_allocator_pkg.sv
// Shared types and width helpers for the polyphonic voice allocator.
//   evt_kind_e  : note-off / note-on tag carried by each outgoing event
//   clog2_min1  : ceil(log2(n)) clamped to at least one bit
package poly_voice_allocator_pkg;

    typedef enum logic {
        EVT_OFF = 1'b0,
        EVT_ON  = 1'b1
    } evt_kind_e;

    // Index width for n items; a single item still needs a one-bit field.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/poly_voice_allocator_key_event_detector.sv
// Key edge capture and pending-event bookkeeping.
//   clk, rst          : clock, async active-high reset
//   keys_i            : debounced key levels
//   i_consume         : issue slot is open this cycle; the current pick is retired
//   o_pick_valid_c    : some key has a pending event
//   o_pick_rel_c      : pick is a release (releases always win over presses)
//   o_pick_key_c      : lowest-index key of the winning class
module key_event_detector
    import poly_voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_KEYS = 12,
    parameter int unsigned KEY_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic                i_consume,
    output logic                o_pick_valid_c,
    output logic                o_pick_rel_c,
    output logic [KEY_W-1:0]    o_pick_key_c
);

    logic [NUM_KEYS-1:0] r_keys_q;
    logic [NUM_KEYS-1:0] r_press_pend;
    logic [NUM_KEYS-1:0] r_rel_pend;

    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_fall;
    logic [NUM_KEYS-1:0] w_src;
    logic [NUM_KEYS-1:0] w_take;
    logic [NUM_KEYS-1:0] w_take_press;
    logic [NUM_KEYS-1:0] w_take_rel;
    logic [NUM_KEYS-1:0] w_press_left;
    logic [NUM_KEYS-1:0] w_rel_left;

    assign w_rise = keys_i & ~r_keys_q;
    assign w_fall = ~keys_i & r_keys_q;

    // Releases first, then presses; lowest key index within the class.
    assign o_pick_rel_c   = |r_rel_pend;
    assign w_src          = o_pick_rel_c ? r_rel_pend : r_press_pend;
    assign o_pick_valid_c = |w_src;

    always_comb begin
        o_pick_key_c = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (w_src[k]) begin
                o_pick_key_c = KEY_W'(k);
            end
        end
    end

    assign w_take       = (i_consume && o_pick_valid_c) ? (NUM_KEYS'(1) << o_pick_key_c) : '0;
    assign w_take_press = o_pick_rel_c ? '0 : w_take;
    assign w_take_rel   = o_pick_rel_c ? w_take : '0;
    assign w_press_left = r_press_pend & ~w_take_press;
    assign w_rel_left   = r_rel_pend & ~w_take_rel;

    // A fall cancels a press that has not been issued yet; a press issued
    // this very cycle already owns a voice, so its fall becomes a release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keys_q     <= '0;
            r_press_pend <= '0;
            r_rel_pend   <= '0;
        end else begin
            r_keys_q     <= keys_i;
            r_press_pend <= (w_press_left & ~w_fall) | w_rise;
            r_rel_pend   <= w_rel_left | (w_fall & ~w_press_left);
        end
    end

endmodule

// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: key edges in, note-on/off events out over valid/ready,
// with the oldest voice stolen when all voices are busy.
//   clk, rst      : clock, async active-high reset
//   keys_i        : debounced key levels, 1 = held
//   voice_active  : per-voice sounding flag
//   voice_key     : per-voice key index, voice v at [v*KEY_W +: KEY_W]
//   evt_valid/evt_ready : event handshake
//   evt_on, evt_key, evt_voice, evt_steal : event payload
module poly_voice_allocator
    import poly_voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = 12,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned AGE_W      = 8,
    localparam int unsigned KEY_W     = clog2_min1(NUM_KEYS),
    localparam int unsigned VOICE_W   = clog2_min1(NUM_VOICES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_KEYS-1:0]         keys_i,
    output logic [NUM_VOICES-1:0]       voice_active,
    output logic [NUM_VOICES*KEY_W-1:0] voice_key,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic                        evt_on,
    output logic [KEY_W-1:0]            evt_key,
    output logic [VOICE_W-1:0]          evt_voice,
    output logic                        evt_steal
);

    logic [NUM_VOICES-1:0] r_active;
    logic [KEY_W-1:0]      r_vkey [NUM_VOICES];
    logic [AGE_W-1:0]      r_age  [NUM_VOICES];
    logic                  r_evt_valid;
    evt_kind_e             r_evt_kind;
    logic [KEY_W-1:0]      r_evt_key;
    logic [VOICE_W-1:0]    r_evt_voice;
    logic                  r_evt_steal;

    logic [NUM_VOICES-1:0] w_active_nxt;
    logic [KEY_W-1:0]      w_vkey_nxt [NUM_VOICES];
    logic [AGE_W-1:0]      w_age_nxt  [NUM_VOICES];
    logic                  w_evt_valid_nxt;
    evt_kind_e             w_evt_kind_nxt;
    logic [KEY_W-1:0]      w_evt_key_nxt;
    logic [VOICE_W-1:0]    w_evt_voice_nxt;
    logic                  w_evt_steal_nxt;

    logic                  w_slot_open;
    logic                  w_pick_valid;
    logic                  w_pick_rel;
    logic [KEY_W-1:0]      w_pick_key;
    logic                  w_hold_found;
    logic [VOICE_W-1:0]    w_hold_v;
    logic                  w_free_found;
    logic [VOICE_W-1:0]    w_free_v;
    logic [VOICE_W-1:0]    w_old_v;
    logic [AGE_W-1:0]      w_old_age;
    logic [VOICE_W-1:0]    w_sel_v;

    assign w_slot_open = !r_evt_valid || evt_ready;

    key_event_detector #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W)
    ) u_key_event_detector (
        .clk            (clk),
        .rst            (rst),
        .keys_i         (keys_i),
        .i_consume      (w_slot_open),
        .o_pick_valid_c (w_pick_valid),
        .o_pick_rel_c   (w_pick_rel),
        .o_pick_key_c   (w_pick_key)
    );

    // Voice searches: holder of the picked key, lowest free voice, oldest voice.
    always_comb begin
        w_hold_found = 1'b0;
        w_hold_v     = '0;
        w_free_found = 1'b0;
        w_free_v     = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (r_active[v] && (r_vkey[v] == w_pick_key)) begin
                w_hold_found = 1'b1;
                w_hold_v     = VOICE_W'(v);
            end
            if (!r_active[v]) begin
                w_free_found = 1'b1;
                w_free_v     = VOICE_W'(v);
            end
        end
        // Strict compare in ascending order keeps ties on the lowest index.
        w_old_v   = '0;
        w_old_age = r_age[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (r_age[v] > w_old_age) begin
                w_old_v   = VOICE_W'(v);
                w_old_age = r_age[v];
            end
        end
        w_sel_v = w_free_found ? w_free_v : w_old_v;
    end

    // Next voice table and next event.
    always_comb begin
        w_active_nxt    = r_active;
        w_vkey_nxt      = r_vkey;
        w_age_nxt       = r_age;
        w_evt_valid_nxt = r_evt_valid;
        w_evt_kind_nxt  = r_evt_kind;
        w_evt_key_nxt   = r_evt_key;
        w_evt_voice_nxt = r_evt_voice;
        w_evt_steal_nxt = r_evt_steal;

        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_active[v] && (r_age[v] != '1)) begin
                w_age_nxt[v] = r_age[v] + AGE_W'(1);
            end
        end

        if (w_slot_open) begin
            w_evt_valid_nxt = 1'b0;
            if (w_pick_valid && w_pick_rel) begin
                // A release whose voice was stolen retires silently.
                if (w_hold_found) begin
                    w_evt_valid_nxt = 1'b1;
                    w_evt_kind_nxt  = EVT_OFF;
                    w_evt_key_nxt   = w_pick_key;
                    w_evt_voice_nxt = w_hold_v;
                    w_evt_steal_nxt = 1'b0;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VOICE_W'(v) == w_hold_v) begin
                            w_active_nxt[v] = 1'b0;
                        end
                    end
                end
            end else if (w_pick_valid) begin
                w_evt_valid_nxt = 1'b1;
                w_evt_kind_nxt  = EVT_ON;
                w_evt_key_nxt   = w_pick_key;
                w_evt_voice_nxt = w_sel_v;
                w_evt_steal_nxt = !w_free_found;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (VOICE_W'(v) == w_sel_v) begin
                        w_active_nxt[v] = 1'b1;
                        w_vkey_nxt[v]   = w_pick_key;
                        w_age_nxt[v]    = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active    <= '0;
            r_evt_valid <= 1'b0;
            r_evt_kind  <= EVT_OFF;
            r_evt_key   <= '0;
            r_evt_voice <= '0;
            r_evt_steal <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_vkey[v] <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_active    <= w_active_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_kind  <= w_evt_kind_nxt;
            r_evt_key   <= w_evt_key_nxt;
            r_evt_voice <= w_evt_voice_nxt;
            r_evt_steal <= w_evt_steal_nxt;
            r_vkey      <= w_vkey_nxt;
            r_age       <= w_age_nxt;
        end
    end

    assign voice_active = r_active;
    assign evt_valid    = r_evt_valid;
    assign evt_on       = (r_evt_kind == EVT_ON);
    assign evt_key      = r_evt_key;
    assign evt_voice    = r_evt_voice;
    assign evt_steal    = r_evt_steal;

    always_comb begin
        voice_key = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_key[v*KEY_W +: KEY_W] = r_vkey[v];
        end
    end

endmodule
